logic_result_fifo: RTL and testbench
====================================

// Module: logic_result_fifo
// PURPOSE
//   Downstream capture stage for the 4-bit result vector of the logical-operator block.
//   Registers each accepted result into a small circular FIFO and presents it on a
//   first-word-fall-through valid/ready output. Keeps a saturating count of accepted samples.
//   Decouples the combinational logic stage from a slower consumer (checker or monitor).
// PARAMETERS
//   DATA_W  4   width of one result word (matches logic-stage out[3:0])
//   DEPTH   8   number of FIFO entries, >=2; need not be a power of two
//   CNT_W   16  width of the saturating sample counter
// PORTS
//   clk         in   1                   single clock; all state changes on posedge
//   rst_n       in   1                   asynchronous, active-low reset
//   in_valid    in   1                   upstream result word present
//   in_ready    out  1                   FIFO can accept; = !full
//   in_data     in   DATA_W              result word (logic-stage out)
//   out_valid   out  1                   head word available; = !empty
//   out_ready   in   1                   consumer takes head word
//   out_data    out  DATA_W              head word mem[rd_ptr]; 0 when empty
//   level       out  $clog2(DEPTH+1)     number of stored words
//   full        out  1                   level == DEPTH
//   empty       out  1                   level == 0
//   sample_cnt  out  CNT_W               accepted handshakes, saturates at all-ones
// BEHAVIOUR
// - Reset (async assert, sync release): wr_ptr=rd_ptr=level=0, sample_cnt=0, empty=1,
//   full=0, in_ready=1, out_valid=0, out_data=0. Storage contents are don't-care.
// - push = in_valid & in_ready; pop = out_valid & out_ready. Both evaluated on the same edge.
// - push: mem[wr_ptr]<=in_data; wr_ptr advances, DEPTH-1 wraps to 0.
// - pop: rd_ptr advances with the same wrap rule.
// - level: +1 on push only; -1 on pop only; unchanged on push&pop.
// - Latency: a word pushed at edge N appears on out_data/out_valid after edge N (1 cycle).
//   No combinational in->out path; out_data is driven from storage only.
// - Full: in_ready=0, so no push, even if pop occurs that cycle (no pass-through).
//   in_ready rises the cycle after the pop.
// - Empty: out_valid=0 and out_data forced to 0; out_ready is ignored.
// - Simultaneous push&pop at level 1..DEPTH-1: both occur; ordering is preserved.
// - Data is strictly FIFO order. No word is lost or duplicated.
// - sample_cnt: +1 per push; holds at 2^CNT_W-1.
// - Reset mid-operation: all words are discarded immediately; outputs return to reset values.
// - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
// CONFIGURATION
//   LOGIC_RESULT_FIFO_DEDUP_EN
//   - Defined: a push whose in_data equals the last written word is handshaken (consumed)
//     but not written.
//     - level and wr_ptr do not change; sample_cnt still increments.
//     - Adds dup_cnt (out, CNT_W, saturating), which increments per discarded word.
//     - First push after reset is always written.
//     - The last-written register is not cleared by pops.
//   - Undefined: every push is written; dup_cnt port and compare logic are absent.
// TESTING
// 1 Reset: rst_n=0 mid-stream with level=5 -> immediately level=0, empty=1, out_valid=0,
//   out_data=0, sample_cnt=0.
// 2 Fill/drain: push 4'h1..4'h8 with out_ready=0 -> full=1, in_ready=0, level=8.
//   Then out_ready=1 -> 1..8 emerge in order; empty=1 after 8 pops.
// 3 Full + pop: at level=8, in_valid=1 data=4'hA with pop -> 4'hA not written that cycle.
//   It is written the next cycle; level 8->7->8.
// 4 Simultaneous: level=3, push 4'hC and pop every cycle for 20 cycles -> level stays 3.
//   Pointers wrap past DEPTH-1; output order is intact.
// 5 Saturation: CNT_W=3, 10 pushes interleaved with pops -> sample_cnt reads 7 and holds.
// 6 DEDUP_EN: push 4'h5,4'h5,4'h6,4'h6,4'h5 -> stored 5,6,5; dup_cnt=2; sample_cnt=5.

Source files
------------

// File: rtl/logic_result_fifo.sv
// Circular first-word-fall-through FIFO capturing logic-stage result words, with a saturating sample counter.
// Optional LOGIC_RESULT_FIFO_DEDUP_EN: drop pushes that repeat the last written word, counted on dup_cnt.
module logic_result_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_W-1:0]             sample_cnt
`ifdef LOGIC_RESULT_FIFO_DEDUP_EN
    ,
    output logic [CNT_W-1:0]             dup_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop, wr_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef LOGIC_RESULT_FIFO_DEDUP_EN
    logic [DATA_W-1:0] last_data;
    logic              last_vld;
    logic              dup;

    // last_vld keeps the first push after reset from matching stale last_data
    assign dup   = last_vld && (in_data == last_data);
    assign wr_en = push && !dup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data <= '0;
            last_vld  <= 1'b0;
            dup_cnt   <= '0;
        end else if (push) begin
            if (dup) begin
                if (!(&dup_cnt)) dup_cnt <= dup_cnt + 1'b1;
            end else begin
                last_data <= in_data;
                last_vld  <= 1'b1;
            end
        end
    end
`else
    assign wr_en = push;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            sample_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && !(&sample_cnt)) sample_cnt <= sample_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_logic_result_fifo.sv
// Scoreboard bench for logic_result_fifo; a second instance with CNT_W=3 covers counter saturation.
module tb_logic_result_fifo;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;

    logic              in_ready, out_valid, full, empty;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        level;
    logic [CNT_W-1:0]  sample_cnt;
    logic              s_in_ready, s_out_valid, s_full, s_empty;
    logic [DATA_W-1:0] s_out_data;
    logic [3:0]        s_level;
    logic [2:0]        s_sample_cnt;
`ifdef LOGIC_RESULT_FIFO_DEDUP_EN
    logic [CNT_W-1:0]  dup_cnt;
    logic [2:0]        s_dup_cnt;
`endif

    logic_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
        .full(full), .empty(empty), .sample_cnt(sample_cnt)
`ifdef LOGIC_RESULT_FIFO_DEDUP_EN
        , .dup_cnt(dup_cnt)
`endif
    );

    logic_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .level(s_level),
        .full(s_full), .empty(s_empty), .sample_cnt(s_sample_cnt)
`ifdef LOGIC_RESULT_FIFO_DEDUP_EN
        , .dup_cnt(s_dup_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [DATA_W-1:0] q[$];
    int                m_cnt;
    int                m_dup;
    logic [DATA_W-1:0] m_last;
    logic              m_last_v;
    logic              did_pop;
    logic [DATA_W-1:0] act_pop, exp_pop;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_cnt = 0; m_dup = 0; m_last = '0; m_last_v = 1'b0;
    endtask

    // Drive one cycle: inputs set after posedge, model updated, DUT sampled 1 time unit after next posedge
    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
        logic m_push, m_pop;
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        m_push  = iv && (q.size() < DEPTH);
        m_pop   = ordy && (q.size() > 0);
        did_pop = m_pop;
        if (m_pop) begin
            act_pop = out_data;
            exp_pop = q.pop_front();
        end
        if (m_push) begin
            m_cnt++;
`ifdef LOGIC_RESULT_FIFO_DEDUP_EN
            if (m_last_v && d == m_last) m_dup++;
            else begin q.push_back(d); m_last = d; m_last_v = 1'b1; end
`else
            q.push_back(d);
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_flags: level=%0d empty=%b full=%b in_ready=%b, want 0 1 0 1", level, empty, full, in_ready);
        end
        n_checks++; if (out_valid !== 1'b0 || out_data !== 4'h0 || sample_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_out: out_valid=%b out_data=%h sample_cnt=%0d, want 0 0 0", out_valid, out_data, sample_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) drive(1'b1, 4'(i + 3), 1'b0);
        n_checks++; if (level !== 4'd5 || sample_cnt !== 16'd5) begin
            n_fail++; $display("FAIL prefill: level=%0d sample_cnt=%0d, want 5 5", level, sample_cnt);
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b0;   // asynchronous, mid-cycle
        #1;
        n_checks++; if (level !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0 || sample_cnt !== 16'd0) begin
            n_fail++; $display("FAIL midreset: level=%0d empty=%b out_valid=%b out_data=%h sample_cnt=%0d, want 0 1 0 0 0",
                               level, empty, out_valid, out_data, sample_cnt);
        end
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            n_checks++; if (level !== 4'(i)) begin
                n_fail++; $display("FAIL fill_level: got %0d want %0d", level, i);
            end
        end
        n_checks++; if (full !== 1'b1 || in_ready !== 1'b0 || level !== 4'd8) begin
            n_fail++; $display("FAIL full_flags: full=%b in_ready=%b level=%0d, want 1 0 8", full, in_ready, level);
        end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 4'h0, 1'b1);
            n_checks++; if (!did_pop || act_pop !== exp_pop || exp_pop !== 4'(i)) begin
                n_fail++; $display("FAIL drain_data: got %h want %h (seq %0d)", act_pop, exp_pop, i);
            end
        end
        n_checks++; if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0) begin
            n_fail++; $display("FAIL drained: empty=%b out_valid=%b out_data=%h, want 1 0 0", empty, out_valid, out_data);
        end
        drive(1'b0, 4'h0, 1'b1);   // pop request while empty is ignored
        n_checks++; if (level !== 4'd0 || did_pop) begin
            n_fail++; $display("FAIL empty_pop: level=%0d, want 0", level);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) drive(1'b1, 4'(i), 1'b0);
        drive(1'b1, 4'hA, 1'b1);
        n_checks++; if (level !== 4'd7 || in_ready !== 1'b1 || act_pop !== exp_pop) begin
            n_fail++; $display("FAIL full_pop: level=%0d in_ready=%b data=%h, want 7 1 %h", level, in_ready, act_pop, exp_pop);
        end
        drive(1'b1, 4'hA, 1'b0);
        n_checks++; if (level !== 4'd8 || full !== 1'b1) begin
            n_fail++; $display("FAIL full_refill: level=%0d full=%b, want 8 1", level, full);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'h0, 1'b1);
            n_checks++; if (act_pop !== exp_pop) begin
                n_fail++; $display("FAIL full_drain: got %h want %h", act_pop, exp_pop);
            end
        end
        n_checks++; if (exp_pop !== 4'hA || empty !== 1'b1) begin
            n_fail++; $display("FAIL full_last: last=%h empty=%b, want a 1", exp_pop, empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) drive(1'b1, 4'(i + 9), 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(i + 12), 1'b1);
            n_checks++; if (level !== 4'd3 || act_pop !== exp_pop) begin
                n_fail++; $display("FAIL simul: level=%0d data=%h, want 3 %h (cycle %0d)", level, act_pop, exp_pop, i);
            end
        end
        while (q.size() > 0) begin
            drive(1'b0, 4'h0, 1'b1);
            n_checks++; if (act_pop !== exp_pop) begin
                n_fail++; $display("FAIL simul_drain: got %h want %h", act_pop, exp_pop);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i), 1'(i % 2));
            n_checks++; if (s_sample_cnt !== 3'(sat(m_cnt, 7))) begin
                n_fail++; $display("FAIL sat_cnt: got %0d want %0d", s_sample_cnt, sat(m_cnt, 7));
            end
        end
        n_checks++; if (s_sample_cnt !== 3'd7 || sample_cnt !== 16'd10) begin
            n_fail++; $display("FAIL sat_final: narrow=%0d wide=%0d, want 7 10", s_sample_cnt, sample_cnt);
        end
    endtask

    task automatic test_dedup();
`ifdef LOGIC_RESULT_FIFO_DEDUP_EN
        logic [DATA_W-1:0] seq [5];
        logic [DATA_W-1:0] want [3];
        seq = '{4'h5, 4'h5, 4'h6, 4'h6, 4'h5};
        want = '{4'h5, 4'h6, 4'h5};
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, seq[i], 1'b0);
        n_checks++; if (dup_cnt !== 16'd2 || sample_cnt !== 16'd5 || level !== 4'd3) begin
            n_fail++; $display("FAIL dedup_cnt: dup=%0d samples=%0d level=%0d, want 2 5 3", dup_cnt, sample_cnt, level);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, 1'b1);
            n_checks++; if (act_pop !== want[i]) begin
                n_fail++; $display("FAIL dedup_data: got %h want %h", act_pop, want[i]);
            end
        end
        drive(1'b1, 4'h5, 1'b0);   // last-written survives pops
        n_checks++; if (level !== 4'd0 || dup_cnt !== 16'd3) begin
            n_fail++; $display("FAIL dedup_after_pop: level=%0d dup=%0d, want 0 3", level, dup_cnt);
        end
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill_drain();
        test_full_pop();
        test_back_to_back();
        test_saturation();
        test_dedup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
